// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter for 16 requesters sharing one 16:1 bit-select mux.
// Grants are held until the request drops or MAX_HOLD cycles elapse, with a dead cycle between grants.
module mux_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] req,
  input  logic [15:0] in,
  output logic [3:0]  sel,
  output logic [15:0] gnt,
  output logic        busy,
  output logic        out,
  output logic        out_valid
);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e      state_q, state_d;
  logic [3:0]  ptr_q, ptr_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  sel_q, sel_d;
  logic [15:0] gnt_q, gnt_d;
  logic        out_q, out_d;
  logic        out_valid_q, out_valid_d;

  logic        found;
  logic [3:0]  pick;
  logic [3:0]  idx;
  logic        release_grant;

  // Wrap-aware scan starting at ptr_q; the first hit wins.
  always_comb begin
    found = 1'b0;
    pick  = ptr_q;
    idx   = ptr_q;
    for (int k = 0; k < 16; k++) begin
      idx = ptr_q + 4'(k);
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  assign release_grant = !req[sel_q] || (cnt_q == 8'(MAX_HOLD - 1));

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    sel_d       = sel_q;
    gnt_d       = gnt_q;
    out_d       = 1'b0;
    out_valid_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          sel_d   = pick;
          gnt_d   = 16'h0001 << pick;
          cnt_d   = 8'd0;
          state_d = StGrant;
        end
      end
      StGrant: begin
        if (release_grant) begin
          gnt_d   = 16'h0000;
          ptr_d   = sel_q + 4'd1;
          state_d = StIdle;
        end else begin
          cnt_d       = cnt_q + 8'd1;
          out_d       = in[sel_q];
          out_valid_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      ptr_q       <= 4'd0;
      cnt_q       <= 8'd0;
      sel_q       <= 4'd0;
      gnt_q       <= 16'h0000;
      out_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      sel_q       <= sel_d;
      gnt_q       <= gnt_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign sel       = sel_q;
  assign gnt       = gnt_q;
  assign busy      = (state_q == StGrant);
  assign out       = out_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Randomized and directed bench for mux_rr_arbiter against a grant-level reference model.
module tb_mux_rr_arbiter;

  localparam int MaxHold = 8;

  logic        clk;
  logic        reset;
  logic [15:0] req;
  logic [15:0] in;
  logic [3:0]  sel;
  logic [15:0] gnt;
  logic        busy;
  logic        out;
  logic        out_valid;

  int n_checks = 0;
  int n_errors = 0;

  // Reference: which requester owns the line (-1 = nobody), how long it has owned it,
  // where the next search begins, and the last grantee index.
  int m_owner = -1;
  int m_held  = 0;
  int m_start = 0;
  int m_sel   = 0;
  bit m_out   = 0;
  bit m_ov    = 0;

  mux_rr_arbiter #(.MAX_HOLD(MaxHold)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .in        (in),
    .sel       (sel),
    .gnt       (gnt),
    .busy      (busy),
    .out       (out),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge(input logic r, input logic [15:0] rq, input logic [15:0] din);
    if (r) begin
      m_owner = -1; m_held = 0; m_start = 0; m_sel = 0; m_out = 0; m_ov = 0;
    end else if (m_owner < 0) begin
      m_out = 0;
      m_ov  = 0;
      for (int k = 0; k < 16; k++) begin
        if (m_owner < 0 && rq[(m_start + k) % 16]) begin
          m_owner = (m_start + k) % 16;
          m_sel   = m_owner;
          m_held  = 0;
        end
      end
    end else if (!rq[m_owner] || m_held + 1 >= MaxHold) begin
      m_out   = 0;
      m_ov    = 0;
      m_start = (m_owner + 1) % 16;
      m_owner = -1;
    end else begin
      m_out  = din[m_owner];
      m_ov   = 1;
      m_held = m_held + 1;
    end
  endtask

  task automatic step(input logic r, input logic [15:0] rq, input logic [15:0] din);
    logic [15:0] exp_gnt;
    @(negedge clk);
    reset = r;
    req   = rq;
    in    = din;
    @(posedge clk);
    model_edge(r, rq, din);
    #1;
    exp_gnt = (m_owner < 0) ? 16'h0000 : (16'h0001 << m_owner);
    check("gnt", 32'(gnt), 32'(exp_gnt));
    check("sel", 32'(sel), 32'(m_sel));
    check("busy", 32'(busy), 32'(m_owner >= 0));
    check("out", 32'(out), 32'(m_out));
    check("out_valid", 32'(out_valid), 32'(m_ov));
  endtask

  task automatic rst2();
    step(1'b1, 16'h0000, 16'h0000);
    step(1'b1, 16'h0000, 16'h0000);
  endtask

  initial begin
    logic [15:0] rq;
    reset = 1'b1;
    req   = '0;
    in    = '0;

    // Reset then single request, with in[5] toggling.
    rst2();
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_sel", 32'(sel), 32'h0);
    check("rst_ov", 32'(out_valid), 32'h0);
    step(1'b0, 16'h0020, 16'h0000);
    check("single_gnt", 32'(gnt), 32'h0020);
    check("single_sel", 32'(sel), 32'd5);
    step(1'b0, 16'h0020, 16'h0020);
    check("single_ov", 32'(out_valid), 32'd1);
    check("single_out", 32'(out), 32'd1);
    for (int i = 0; i < 8; i++) step(1'b0, 16'h0020, (i % 2 == 0) ? 16'h0000 : 16'h0020);

    // Hold limit with a single continuous requester.
    rst2();
    for (int i = 0; i < 30; i++) step(1'b0, 16'h0001, 16'($urandom));

    // Full rotation.
    rst2();
    for (int i = 0; i < 200; i++) step(1'b0, 16'hFFFF, 16'($urandom));

    // Wrap and priority: grant 14, release, then bits 15,14,0.
    rst2();
    step(1'b0, 16'h4000, 16'h0000);
    check("wrap_g14", 32'(sel), 32'd14);
    step(1'b0, 16'h0000, 16'h0000);
    step(1'b0, 16'hC001, 16'h0000);
    check("wrap_g15", 32'(sel), 32'd15);
    for (int i = 0; i < 30; i++) step(1'b0, 16'hC001, 16'($urandom));

    // Early release, then regrant and reset mid-grant.
    rst2();
    for (int i = 0; i < 3; i++) step(1'b0, 16'h0008, 16'hFFFF);
    for (int i = 0; i < 2; i++) step(1'b0, 16'h0000, 16'hFFFF);
    for (int i = 0; i < 5; i++) step(1'b0, 16'h0008, 16'hFFFF);
    step(1'b1, 16'h0008, 16'hFFFF);
    check("midrst_gnt", 32'(gnt), 32'h0);
    check("midrst_busy", 32'(busy), 32'h0);
    check("midrst_out", 32'(out), 32'h0);
    step(1'b0, 16'hFFFF, 16'h0000);
    check("midrst_ptr0", 32'(gnt), 32'h0001);

    // Random traffic with occasional resets.
    rst2();
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(3))
        0: rq = 16'($urandom);
        1: rq = 16'h0001 << $urandom_range(15);
        2: rq = 16'($urandom) & 16'($urandom) & 16'($urandom);
        default: rq = req;
      endcase
      step(($urandom_range(199) == 0), rq, 16'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
